// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide scheduler.
package md_pkg;

  // md_op encodings from decode
  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;
  localparam logic [2:0] MD_RSVD  = 3'b111;

  // Scheduler states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Default busy lengths
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Busy-cycle counter width
  localparam int unsigned CNT_W = 16;

  // True for ops that occupy the unit for several cycles
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing HI/LO results.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_b_safe;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Products, sign-magnitude division, and result selection by op
  always_comb begin
    // Low 64 bits of a product of sign-extended operands equal the signed product
    prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u     = {32'd0, a} * {32'd0, b};

    // Signed division runs on magnitudes so INT_MIN / -1 stays well defined
    signed_div = (op == MD_DIV);
    div_a      = (signed_div && a[31]) ? (~a + 32'd1) : a;
    div_b      = (signed_div && b[31]) ? (~b + 32'd1) : b;
    div_b_safe = (div_b == '0) ? 32'd1 : div_b;
    quo        = div_a / div_b_safe;
    rem        = div_a % div_b_safe;
    q_fix      = (signed_div && (a[31] ^ b[31])) ? (~quo + 32'd1) : quo;
    r_fix      = (signed_div && a[31]) ? (~rem + 32'd1) : rem;

    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MD_DIV, MD_DIVU: begin
        res_hi   = r_fix;
        res_lo   = q_fix;
        div_zero = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: sequences fixed-latency ops and owns HI/LO.
module md_sched
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]       state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_dz;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_zero;

  md_arith u_arith (
    .op       (md_op),
    .a        (rs_val),
    .b        (rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // Busy is a pure decode of the state register, so it is glitch-free
  assign busy  = (state != ST_IDLE);

  // Hold D when it touches HI/LO while a long op is in flight or entering
  assign stall = d_uses_md & (busy | (start & is_long_op(md_op)));

  // FSM, busy counter, pending result and architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_dz <= 1'b0;
                counter <= CNT_W'(MULT_CYCLES);
                state   <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_dz <= div_zero;
                counter <= CNT_W'(DIV_CYCLES);
                state   <= ST_DIV;
              end
              MD_MTHI: hi <= rs_val;
              MD_MTLO: lo <= rs_val;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          counter <= counter - 1'b1;
          if (counter == CNT_W'(1)) begin
            if (!pend_dz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: completions are checked against queued expectations.
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = MD_NONE;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        d_uses_md = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] len;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_op(input string nm, input logic [31:0] h, input logic [31:0] l,
                           input logic [31:0] n);
    exp_t e;
    e.name = nm; e.hi = h; e.lo = l; e.len = n;
    exp_q.push_back(e);
  endtask

  // Drives start for one cycle; returns at the next negedge with start low
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, %0d completions outstanding", nm, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: a busy run ending is a completion; compare length and HI/LO
  initial begin
    logic     prev_busy;
    int       run;
    exp_t     e;
    prev_busy = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      #1;
      if (busy === 1'b1) begin
        run++;
      end else begin
        if (prev_busy) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_completion: got len %0d want none", run);
          end else begin
            e = exp_q.pop_front();
            check({e.name, "_len"}, 32'(run), e.len);
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
          end
        end
        run = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    d_uses_md = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    d_uses_md = 1'b0;

    // Reset during busy cycle 3 aborts the MULT
    expect_op("rst_mid", 32'd0, 32'd0, 32'd3);
    issue(MD_MULT, 32'd5, 32'd7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    drain("rst_mid");

    // MULT -2 * 3 with stall observation
    expect_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd5);
    @(negedge clk);
    d_uses_md = 1'b1;
    start = 1'b1; md_op = MD_MULT; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    #1;
    check("mult_stall_T", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0; md_op = MD_NONE;
      #1;
      check($sformatf("mult_stall_T%0d", c), {31'd0, stall}, 32'd1);
    end
    @(negedge clk);
    #1;
    check("mult_stall_T6", {31'd0, stall}, 32'd0);
    d_uses_md = 1'b0;
    drain("mult");

    // MULTU max * max
    expect_op("multu", 32'hFFFF_FFFE, 32'h0000_0001, 32'd5);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain("multu");

    // DIV -7 / 2
    expect_op("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd10);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    drain("div");

    // MTHI/MTLO preload, then DIVU by zero leaves them alone
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    #1;
    check("mthi_pre", hi, 32'h1234_5678);
    issue(MD_MTLO, 32'h1234_5678, 32'd0);
    #1;
    check("mtlo_pre", lo, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    expect_op("divu_zero", 32'h1234_5678, 32'h1234_5678, 32'd10);
    issue(MD_DIVU, 32'd7, 32'd0);
    drain("divu_zero");

    // MTHI takes effect next cycle without busy
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    #1;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo", lo, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
    check("mthi_busy2", {31'd0, busy}, 32'd0);

    // Reserved op does nothing
    issue(MD_RSVD, 32'd1, 32'd1);
    #1;
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi, 32'hDEAD_BEEF);

    // DIV 100 / 7, with a second start while busy that must be ignored
    expect_op("div_ign", 32'd2, 32'd14, 32'd10);
    issue(MD_DIV, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; md_op = MD_DIV; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    drain("div_ign");

    // INT_MIN / -1
    expect_op("div_ovf", 32'd0, 32'h8000_0000, 32'd10);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    drain("div_ovf");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
